uart_tx_sched: RTL and testbench

//  Round-robin scheduler sharing one tx_engine among N_REQ byte producers.
//  - Picks one pending requester, drives the engine's load/out_port, acks the requester.
//  - Sequences the engine by watching txrdy, so only one byte is in flight at a time.
//  - Sits between producer logic (port-mapped writers) and tx_engine, replacing direct load decode.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rr_pick.sv | 30 +++
 rtl/uart_tx_sched.sv | 115 +++++++++++
 tb/tb_uart_tx_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding, default byte width and the
// baud divisor table (clk_sys cycles per bit at 50 MHz) used by the top level.
package uart_pkg;

    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY_WAIT = 2'd1,
        ST_DONE_WAIT = 2'd2
    } sched_state_t;

    // 1200, 2400, 4800, 9600, 14400, 19200, 28800, 38400, 57600, 115200, 230400, 460800 baud
    localparam int unsigned BAUD_K [0:11] = '{
        41667, 20833, 10417, 5208, 3472, 2604, 1736, 1302, 868, 434, 217, 109
    };

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: rotate req so last+1 sits at bit 0, take the lowest set bit,
// then rotate the index back.
module uart_rr_pick #(
    parameter int  N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [IW-1:0]    winner,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [IW-1:0]    off;
    int               idx;

    always_comb begin
        rot = N_REQ'({req, req} >> (int'(last) + 1));
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IW'(i);
        end
        idx = int'(off) + int'(last) + 1;
        if (idx >= N_REQ) idx = idx - N_REQ;
        winner = IW'(idx);
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one tx_engine among N_REQ byte producers; only one
// byte is in flight at a time, sequenced by watching the engine's txrdy.
//
//   state        | meaning
//   ST_IDLE      | waiting for enable & txrdy & a pending request
//   ST_BUSY_WAIT | byte loaded, waiting for txrdy to fall (bounded by TO_CYC)
//   ST_DONE_WAIT | engine shifting the frame, waiting for txrdy to return
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int  N_REQ  = 4,
    parameter int  DW     = DW_DEF,
    parameter int  TO_CYC = 15,
    localparam int IW     = $clog2(N_REQ),
    localparam int CW     = $clog2(TO_CYC + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    ack,
    input  logic                txrdy,
    output logic                load,
    output logic [DW-1:0]       out_port,
    output logic [IW-1:0]       gnt_id,
    output logic                busy,
    output logic                err
);

    sched_state_t     state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx, cnt_inc;
    logic [IW-1:0]    last, last_nx;
    logic [IW-1:0]    winner;
    logic             any;
    logic             load_nx, err_nx;
    logic [N_REQ-1:0] ack_nx;
    logic [DW-1:0]    out_nx;
    logic [IW-1:0]    gnt_nx;

    uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .last   (last),
        .winner (winner),
        .any    (any)
    );

    // Saturating so a stalled count can never wrap back into range.
    assign cnt_inc = (cnt == CW'(TO_CYC)) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last;
        out_nx   = out_port;
        gnt_nx   = gnt_id;
        load_nx  = 1'b0;
        ack_nx   = '0;
        err_nx   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && txrdy && any) begin
                    state_nx       = ST_BUSY_WAIT;
                    load_nx        = 1'b1;
                    ack_nx[winner] = 1'b1;
                    out_nx         = req_data[int'(winner)*DW +: DW];
                    gnt_nx         = winner;
                    last_nx        = winner;
                    cnt_nx         = '0;
                end
            end
            ST_BUSY_WAIT: begin
                if (!txrdy) begin
                    state_nx = ST_DONE_WAIT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc == CW'(TO_CYC)) begin
                        err_nx   = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_DONE_WAIT: begin
                if (txrdy) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            last     <= IW'(N_REQ - 1);
            load     <= 1'b0;
            ack      <= '0;
            out_port <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            last     <= last_nx;
            load     <= load_nx;
            ack      <= ack_nx;
            out_port <= out_nx;
            gnt_id   <= gnt_nx;
            busy     <= (state_nx != ST_IDLE);
            err      <= err_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched: random producers, a tx_engine model and a
// transaction-level reference model of the scheduler.
module tb_uart_tx_sched;

    localparam int N_REQ  = 4;
    localparam int DW     = 8;
    localparam int TO_CYC = 15;
    localparam int IW     = $clog2(N_REQ);
    localparam int N_CYC  = 4000;

    logic                clk      = 1'b0;
    logic                reset    = 1'b0;
    logic                enable   = 1'b0;
    logic                txrdy    = 1'b1;
    logic [N_REQ-1:0]    req      = '0;
    logic [N_REQ*DW-1:0] req_data = '0;
    logic [N_REQ-1:0]    ack;
    logic                load;
    logic [DW-1:0]       out_port;
    logic [IW-1:0]       gnt_id;
    logic                busy;
    logic                err;

    uart_tx_sched #(.N_REQ(N_REQ), .DW(DW), .TO_CYC(TO_CYC)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .txrdy    (txrdy),
        .load     (load),
        .out_port (out_port),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: "free" scheduler, whether txrdy has fallen since the load,
    // and the step index of the last load.
    bit               m_free;
    bit               m_fell;
    int               m_last;
    int               m_step;
    int               m_load_step;
    logic             e_load;
    logic [N_REQ-1:0] e_ack;
    logic [DW-1:0]    e_out;
    logic [IW-1:0]    e_gnt;
    logic             e_busy;
    logic             e_err;

    // Engine model: 0 idle, 1 delay before txrdy falls, 2 shifting frame, 3 never falls.
    int eng_mode = 0;
    int eng_cnt  = 0;
    int eng_len  = 0;

    task automatic model_reset();
        m_free = 1'b1;
        m_fell = 1'b0;
        m_last = N_REQ - 1;
        e_load = 1'b0;
        e_ack  = '0;
        e_out  = '0;
        e_gnt  = '0;
        e_busy = 1'b0;
        e_err  = 1'b0;
    endtask

    // Predicts outputs after the next rising edge from the inputs now applied.
    task automatic model_step();
        int w;
        m_step++;
        e_load = 1'b0;
        e_ack  = '0;
        e_err  = 1'b0;
        if (m_free) begin
            if (enable && txrdy && req != '0) begin
                w = -1;
                for (int k = 1; k <= N_REQ; k++) begin
                    if (w < 0 && req[(m_last + k) % N_REQ]) w = (m_last + k) % N_REQ;
                end
                e_load      = 1'b1;
                e_ack       = N_REQ'(1) << w;
                e_out       = req_data[w*DW +: DW];
                e_gnt       = IW'(w);
                m_last      = w;
                m_free      = 1'b0;
                m_fell      = 1'b0;
                m_load_step = m_step;
                e_busy      = 1'b1;
            end
        end else if (!m_fell) begin
            if (!txrdy) begin
                m_fell = 1'b1;
            end else if (m_step - m_load_step == TO_CYC) begin
                e_err  = 1'b1;
                m_free = 1'b1;
                e_busy = 1'b0;
            end
        end else if (txrdy) begin
            m_free = 1'b1;
            e_busy = 1'b0;
        end
    endtask

    task automatic drive_engine();
        if (e_load) begin
            if ($urandom_range(0, 7) == 0) begin
                eng_mode = 3;
            end else begin
                eng_mode = 1;
                eng_cnt  = $urandom_range(0, 3);
                eng_len  = $urandom_range(1, 20);
            end
        end
        case (eng_mode)
            1: begin
                if (eng_cnt == 0) begin
                    eng_mode = 2;
                    eng_cnt  = eng_len;
                    txrdy    = 1'b0;
                end else begin
                    eng_cnt--;
                    txrdy = 1'b1;
                end
            end
            2: begin
                txrdy = 1'b0;
                eng_cnt--;
                if (eng_cnt <= 0) eng_mode = 0;
            end
            3: begin
                txrdy = 1'b1;
                if (e_err) eng_mode = 0;
            end
            default: txrdy = ($urandom_range(0, 15) != 0);
        endcase
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N_REQ; i++) begin
            if (e_ack[i]) begin
                if ($urandom_range(0, 3) == 0) req_data[i*DW +: DW] = DW'($urandom);
                else req[i] = 1'b0;
            end else if (req[i]) begin
                if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                req[i]                = 1'b1;
                req_data[i*DW +: DW] = DW'($urandom);
            end
        end
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "load"}, 32'(load), 32'(e_load));
        chk({pfx, "ack"}, 32'(ack), 32'(e_ack));
        chk({pfx, "out_port"}, 32'(out_port), 32'(e_out));
        chk({pfx, "gnt_id"}, 32'(gnt_id), 32'(e_gnt));
        chk({pfx, "busy"}, 32'(busy), 32'(e_busy));
        chk({pfx, "err"}, 32'(err), 32'(e_err));
    endtask

    initial begin
        bit rst_pending;
        int rst_wait;
        rst_pending = 1'b0;
        rst_wait    = 0;
        m_step      = 0;
        m_load_step = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset_");
        reset  = 1'b1;
        enable = 1'b1;
        model_step();

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            check_outputs("");
            if (cyc == 1500 || cyc == 3000) begin
                rst_pending = 1'b1;
                rst_wait    = 0;
            end
            if (rst_pending && !m_free && m_fell) begin
                rst_pending = 1'b0;
                #2 reset = 1'b0;
                #1;
                chk("async_rst_load", 32'(load), 32'(0));
                chk("async_rst_ack", 32'(ack), 32'(0));
                chk("async_rst_busy", 32'(busy), 32'(0));
                chk("async_rst_err", 32'(err), 32'(0));
                chk("async_rst_out_port", 32'(out_port), 32'(0));
                chk("async_rst_gnt_id", 32'(gnt_id), 32'(0));
                req                   = 4'b1001;
                req_data[0 +: DW]     = DW'($urandom);
                req_data[3*DW +: DW] = DW'($urandom);
                txrdy                 = 1'b1;
                eng_mode              = 0;
                enable                = 1'b1;
                @(negedge clk);
                chk("held_rst_load", 32'(load), 32'(0));
                reset = 1'b1;
                model_reset();
            end else begin
                if (rst_pending) begin
                    rst_wait++;
                    if (rst_wait > 400) begin
                        chk("reset_window_reached", 32'(rst_wait <= 400), 32'(1));
                        rst_pending = 1'b0;
                    end
                end
                if (cyc % 25 == 0) enable = ($urandom_range(0, 3) != 0);
                drive_engine();
                drive_reqs();
            end
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
